mmio_timer_responder: RTL and testbench
=======================================

# mmio_timer_responder

Memory-mapped bus responder on the RV32I core's data bus: decodes `bus_addr`, accepts `bus_wren` stores, and returns `bus_rddata` for `bus_rden` loads. Behind the decode sit:
- a 32-bit prescaled timer with compare match, auto-reload and interrupt;
- a 32-bit GPIO output register;
- a synchronized 32-bit GPIO input port.

It is the peripheral end of the core's load/store interface and sits beside data memory on that bus.

## Interface
Parameters:
- `BASE_ADDR`, 32'h1000_0000: base of the 64-byte register window; must be 64-byte aligned.
- `GPIO_OUT_RESET`, 32'h0: reset value of `gpio_out`.

Ports:
- `clk`  input  1  core clock; all state on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `bus_addr`  input  32  byte address from the core.
- `bus_wrdata`  input  32  store data.
- `bus_wren`  input  1  store strobe, one cycle per access.
- `bus_rden`  input  1  load strobe, one cycle per access.
- `bus_rddata`  output  32  load data; 0 when not selected.
- `sel`  output  1  `bus_addr` falls inside the window.
- `irq`  output  1  timer interrupt request, level.
- `gpio_in`  input  32  asynchronous external inputs.
- `gpio_out`  output  32  registered outputs.

## Operation
- Decode: `sel` = (`bus_addr[31:6]` == `BASE_ADDR[31:6]`). Offset = `bus_addr[5:2]`; `bus_addr[1:0]` is ignored. All accesses are full-word.
- Register map (word offsets, byte address in parentheses):
  - 0 (0x00) CTRL: [0] EN, [1] AUTORELOAD, [2] IE, [15:8] PRESCALE; other bits read 0.
  - 1 (0x04) COUNT: RW; a write loads the counter.
  - 2 (0x08) COMPARE: RW.
  - 3 (0x0C) STATUS: [0] MATCH, [1] OVF; both sticky; write-1-to-clear.
  - 4 (0x10) GPIO_OUT: RW.
  - 5 (0x14) GPIO_IN: RO, the synchronized input.
  - Offsets 6-15: read 0, writes ignored.
- Writes take effect on the rising edge where `bus_wren` & `sel`. Writes to RO or unmapped offsets have no effect.
- Reads: `bus_rddata` is purely combinational from current state whenever `sel` & `bus_rden`; otherwise it is 0. Outputs can be OR-combined with other responders. Reads have no side effects.
- `bus_wren` and `bus_rden` high together: the read returns the pre-write value; the write commits at the edge.
- Prescaler: an 8-bit `presc_cnt`, running only while EN=1.
  - tick = EN & (`presc_cnt` == PRESCALE).
  - On tick `presc_cnt` returns to 0; otherwise it increments.
  - PRESCALE=0 gives a tick every cycle.
  - Any CTRL write clears `presc_cnt`.
- Counter, on tick:
  - If COUNT == COMPARE: set MATCH. COUNT becomes 0 if AUTORELOAD=1, else COUNT+1.
  - Else COUNT becomes COUNT+1, modulo 2^32. The wrap from 32'hFFFF_FFFF to 0 sets OVF.
- With EN=0, COUNT and `presc_cnt` hold their values.
- Priorities:
  - A bus write to COUNT beats a tick in the same cycle: the written value is loaded and no match/overflow is evaluated that cycle.
  - A hardware set of MATCH/OVF beats a W1C clear in the same cycle: the flag stays set.
- `irq` = MATCH & IE, driven from flops with no combinational path from the bus.
- GPIO_IN passes through a 2-flop synchronizer. GPIO_IN reads return the second stage.

## Timing
- Reset (`rst`=0, asynchronous): CTRL, COUNT, COMPARE, STATUS, `presc_cnt` and both synchronizer stages go to 0; `gpio_out` goes to `GPIO_OUT_RESET`; `irq`=0. While `rst`=0 and no access is made, `bus_rddata`=0 and `sel` follows `bus_addr`.
- Reset asserted mid-operation discards any in-flight count or pending write. State resumes from reset values on the first edge after release.
- Read latency: 0 cycles; data is valid in the same cycle as `bus_rden`.
- Write latency: the new value is visible on reads in the cycle after the write edge.
- Timer: with EN set at edge N and PRESCALE=P, the first tick happens in the cycle after edge N+P, so COUNT first changes at edge N+P+1. COUNT then increments every P+1 cycles.
- MATCH and `irq` rise at the edge of the matching tick.
- GPIO: a `gpio_in` change is visible on GPIO_IN reads 2 edges later. `gpio_out` updates at the write edge.

## Structure
- Shared package `mmio_pkg`:
  - register offset constants (`MMIO_CTRL_OFS` ... `MMIO_GPIO_IN_OFS`);
  - a packed `mmio_ctrl_t` struct (EN, AUTORELOAD, IE, PRESCALE);
  - STATUS bit index constants.
- One sub-module, `mmio_timer_core`, containing the prescaler, counter, compare and flag logic. The top level holds the decode, the read mux, GPIO and the synchronizer.

## Test plan
- Reset with `GPIO_OUT_RESET`=32'hA5: `gpio_out`=32'hA5, `irq`=0. Reads of CTRL, COUNT and STATUS return 0, and `bus_rddata`=0 for address 32'h2000_0000 with `sel`=0.
- PRESCALE=0, COMPARE=3, AUTORELOAD=1, IE=1, EN=1: COUNT sequence 1,2,3,0,1. MATCH and `irq` go high at the 3→0 edge. Writing 32'h1 to STATUS drops `irq` the next cycle.
- PRESCALE=4, EN=1: COUNT advances once every 5 cycles. Writing CTRL with EN=0 mid-period holds COUNT.
- COUNT=32'hFFFF_FFFE, COMPARE=0, AUTORELOAD=0: after 2 ticks COUNT=0, OVF=1 and MATCH=0. The next tick sets MATCH.
- Same-cycle conflicts:
  - COUNT write of 32'h10 on a tick edge gives COUNT=32'h10.
  - W1C of MATCH on the cycle MATCH is re-set leaves MATCH=1.
- GPIO: `gpio_in` set to 32'hDEAD_BEEF gives GPIO_IN reads of the old value for 2 edges, then 32'hDEAD_BEEF. A write to GPIO_IN is ignored. Reads at offsets 0x18-0x3C return 0.

Source files
------------

// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared register map, control layout and status bit indices
package mmio_pkg;

   localparam logic [3:0] MMIO_CTRL_OFS     = 4'd0;
   localparam logic [3:0] MMIO_COUNT_OFS    = 4'd1;
   localparam logic [3:0] MMIO_COMPARE_OFS  = 4'd2;
   localparam logic [3:0] MMIO_STATUS_OFS   = 4'd3;
   localparam logic [3:0] MMIO_GPIO_OUT_OFS = 4'd4;
   localparam logic [3:0] MMIO_GPIO_IN_OFS  = 4'd5;

   localparam int STATUS_MATCH_BIT = 0;
   localparam int STATUS_OVF_BIT   = 1;

   typedef struct packed {
      logic [7:0] prescale;
      logic       ie;
      logic       autoreload;
      logic       en;
   } mmio_ctrl_t;

   // Bus view of CTRL: EN/AUTORELOAD/IE in [2:0], PRESCALE in [15:8], rest zero.
   function automatic logic [31:0] ctrl_to_word(input mmio_ctrl_t c);
      return {16'h0000, c.prescale, 5'b00000, c.ie, c.autoreload, c.en};
   endfunction

endpackage

// File: rtl/mmio_timer_core.sv
// rtl/mmio_timer_core.sv - prescaler, 32-bit counter, compare match and sticky flags
module mmio_timer_core
   import mmio_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        ctrl_we_i,
   input  logic        count_we_i,
   input  logic        compare_we_i,
   input  logic        status_we_i,
   input  logic [31:0] wdata_i,
   output mmio_ctrl_t  ctrl_o,
   output logic [31:0] count_o,
   output logic [31:0] compare_o,
   output logic [1:0]  status_o,
   output logic        irq_o
);

   mmio_ctrl_t  ctrl_q, ctrl_d;
   logic [7:0]  presc_q, presc_d;
   logic [31:0] count_q, count_d;
   logic [31:0] compare_q, compare_d;
   logic [1:0]  status_q, status_d;
   logic        tick;
   logic        match_set;
   logic        ovf_set;
   logic [1:0]  status_clr;

   assign tick = ctrl_q.en && (presc_q == ctrl_q.prescale);

   // Register writes for CTRL and COMPARE.
   always_comb begin
      ctrl_d    = ctrl_q;
      compare_d = compare_q;
      if (ctrl_we_i) begin
         ctrl_d.en         = wdata_i[0];
         ctrl_d.autoreload = wdata_i[1];
         ctrl_d.ie         = wdata_i[2];
         ctrl_d.prescale   = wdata_i[15:8];
      end
      if (compare_we_i) begin
         compare_d = wdata_i;
      end
   end

   // Prescaler, counter and flag next state; a bus COUNT write suppresses the tick.
   always_comb begin
      presc_d   = presc_q;
      count_d   = count_q;
      match_set = 1'b0;
      ovf_set   = 1'b0;
      if (ctrl_we_i) begin
         presc_d = '0;
      end else if (ctrl_q.en) begin
         presc_d = tick ? 8'd0 : presc_q + 8'd1;
      end
      if (count_we_i) begin
         count_d = wdata_i;
      end else if (tick) begin
         if (count_q == compare_q) begin
            match_set = 1'b1;
            count_d   = ctrl_q.autoreload ? 32'd0 : count_q + 32'd1;
         end else begin
            count_d = count_q + 32'd1;
            ovf_set = (count_q == 32'hFFFF_FFFF);
         end
      end
      status_clr = status_we_i ? wdata_i[1:0] : 2'b00;
      status_d   = status_q & ~status_clr;
      if (match_set) status_d[STATUS_MATCH_BIT] = 1'b1;
      if (ovf_set)   status_d[STATUS_OVF_BIT]   = 1'b1;
   end

   // Timer state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctrl_q    <= '0;
         presc_q   <= '0;
         count_q   <= '0;
         compare_q <= '0;
         status_q  <= '0;
      end else begin
         ctrl_q    <= ctrl_d;
         presc_q   <= presc_d;
         count_q   <= count_d;
         compare_q <= compare_d;
         status_q  <= status_d;
      end
   end

   assign ctrl_o    = ctrl_q;
   assign count_o   = count_q;
   assign compare_o = compare_q;
   assign status_o  = status_q;
   assign irq_o     = status_q[STATUS_MATCH_BIT] & ctrl_q.ie;

endmodule

// File: rtl/mmio_timer_responder.sv
// rtl/mmio_timer_responder.sv - bus decode, read mux, GPIO and input synchronizer
module mmio_timer_responder
   import mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
   parameter logic [31:0] GPIO_OUT_RESET = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] bus_addr,
   input  logic [31:0] bus_wrdata,
   input  logic        bus_wren,
   input  logic        bus_rden,
   output logic [31:0] bus_rddata,
   output logic        sel,
   output logic        irq,
   input  logic [31:0] gpio_in,
   output logic [31:0] gpio_out
);

   logic [3:0]  ofs;
   logic        wr;
   logic        unused_byte_ofs;
   mmio_ctrl_t  ctrl;
   logic [31:0] count;
   logic [31:0] compare;
   logic [1:0]  status;
   logic [31:0] gpio_out_q, gpio_out_d;
   logic [31:0] sync1_q, sync2_q;

   assign sel             = (bus_addr[31:6] == BASE_ADDR[31:6]);
   assign ofs             = bus_addr[5:2];
   assign unused_byte_ofs = ^bus_addr[1:0];
   assign wr              = bus_wren & sel;

   mmio_timer_core u_timer (
      .clk          (clk),
      .rst          (rst),
      .ctrl_we_i    (wr && (ofs == MMIO_CTRL_OFS)),
      .count_we_i   (wr && (ofs == MMIO_COUNT_OFS)),
      .compare_we_i (wr && (ofs == MMIO_COMPARE_OFS)),
      .status_we_i  (wr && (ofs == MMIO_STATUS_OFS)),
      .wdata_i      (bus_wrdata),
      .ctrl_o       (ctrl),
      .count_o      (count),
      .compare_o    (compare),
      .status_o     (status),
      .irq_o        (irq)
   );

   // GPIO output register write.
   always_comb begin
      gpio_out_d = gpio_out_q;
      if (wr && (ofs == MMIO_GPIO_OUT_OFS)) begin
         gpio_out_d = bus_wrdata;
      end
   end

   // GPIO output register and two-stage input synchronizer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gpio_out_q <= GPIO_OUT_RESET;
         sync1_q    <= '0;
         sync2_q    <= '0;
      end else begin
         gpio_out_q <= gpio_out_d;
         sync1_q    <= gpio_in;
         sync2_q    <= sync1_q;
      end
   end

   assign gpio_out = gpio_out_q;

   // Zero-latency read mux; zero when not addressed so responders can be OR-ed.
   always_comb begin
      bus_rddata = '0;
      if (sel && bus_rden) begin
         case (ofs)
            MMIO_CTRL_OFS:     bus_rddata = ctrl_to_word(ctrl);
            MMIO_COUNT_OFS:    bus_rddata = count;
            MMIO_COMPARE_OFS:  bus_rddata = compare;
            MMIO_STATUS_OFS:   bus_rddata = {30'd0, status};
            MMIO_GPIO_OUT_OFS: bus_rddata = gpio_out_q;
            MMIO_GPIO_IN_OFS:  bus_rddata = sync2_q;
            default:           bus_rddata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_timer_responder.sv
// tb/tb_mmio_timer_responder.sv - self-checking bench for mmio_timer_responder
module tb_mmio_timer_responder;

   localparam logic [31:0] BASE     = 32'h1000_0000;
   localparam logic [31:0] A_CTRL   = BASE + 32'h00;
   localparam logic [31:0] A_COUNT  = BASE + 32'h04;
   localparam logic [31:0] A_CMP    = BASE + 32'h08;
   localparam logic [31:0] A_STATUS = BASE + 32'h0C;
   localparam logic [31:0] A_GOUT   = BASE + 32'h10;
   localparam logic [31:0] A_GIN    = BASE + 32'h14;

   logic        clk;
   logic        rst;
   logic [31:0] bus_addr;
   logic [31:0] bus_wrdata;
   logic        bus_wren;
   logic        bus_rden;
   logic [31:0] bus_rddata;
   logic        sel;
   logic        irq;
   logic [31:0] gpio_in;
   logic [31:0] gpio_out;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      string       name;
      logic        do_wr;
      logic [31:0] waddr;
      logic [31:0] wdata;
      logic [31:0] raddr;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[$];

   mmio_timer_responder #(
      .BASE_ADDR      (BASE),
      .GPIO_OUT_RESET (32'h0000_00A5)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus_addr   (bus_addr),
      .bus_wrdata (bus_wrdata),
      .bus_wren   (bus_wren),
      .bus_rden   (bus_rden),
      .bus_rddata (bus_rddata),
      .sel        (sel),
      .irq        (irq),
      .gpio_in    (gpio_in),
      .gpio_out   (gpio_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus_addr   = a;
      bus_wrdata = d;
      bus_wren   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus_wren   = 1'b0;
   endtask

   task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
      sb_t e;
      sb_q.push_back('{name, exp});
      bus_addr = a;
      bus_rden = 1'b1;
      #1;
      e = sb_q.pop_front();
      chk(e.name, bus_rddata, e.exp);
      bus_rden = 1'b0;
   endtask

   initial begin
      int seq[5];
      rst        = 1'b0;
      bus_addr   = BASE;
      bus_wrdata = '0;
      bus_wren   = 1'b0;
      bus_rden   = 1'b0;
      gpio_in    = '0;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_gpio_out", gpio_out, 32'h0000_00A5);
      chk("rst_irq", {31'd0, irq}, 32'd0);
      chk("rst_rddata_idle", bus_rddata, 32'd0);
      chk("rst_sel_in_window", {31'd0, sel}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rd("rst_ctrl", A_CTRL, 32'd0);
      rd("rst_count", A_COUNT, 32'd0);
      rd("rst_status", A_STATUS, 32'd0);
      rd("outside_rddata", 32'h2000_0000, 32'd0);
      chk("outside_sel", {31'd0, sel}, 32'd0);

      // register table
      vecs.push_back('{"compare_rw", 1'b1, A_CMP, 32'h1234_5678, A_CMP, 32'h1234_5678});
      vecs.push_back('{"gpio_out_rw", 1'b1, A_GOUT, 32'hCAFE_F00D, A_GOUT, 32'hCAFE_F00D});
      vecs.push_back('{"ctrl_mask", 1'b1, A_CTRL, 32'hFFFF_AB06, A_CTRL, 32'h0000_AB06});
      vecs.push_back('{"ctrl_clear", 1'b1, A_CTRL, 32'h0, A_CTRL, 32'h0});
      vecs.push_back('{"out_of_window_wr", 1'b1, 32'h2000_0010, 32'h1, A_GOUT, 32'hCAFE_F00D});
      vecs.push_back('{"gpio_in_ro", 1'b1, A_GIN, 32'hFFFF_FFFF, A_GIN, 32'h0});
      vecs.push_back('{"byte_ofs_ignored", 1'b1, BASE + 32'h0B, 32'h0000_ABCD, A_CMP, 32'h0000_ABCD});
      for (int o = 6; o < 16; o++) begin
         vecs.push_back('{$sformatf("unmapped_%0h", o * 4), 1'b1, BASE + 32'(o * 4),
                          32'hFFFF_FFFF, BASE + 32'(o * 4), 32'h0});
      end
      foreach (vecs[i]) begin
         if (vecs[i].do_wr) wr(vecs[i].waddr, vecs[i].wdata);
         rd(vecs[i].name, vecs[i].raddr, vecs[i].exp);
      end
      chk("gpio_out_pin", gpio_out, 32'hCAFE_F00D);
      rd("compare_not_aliased", A_CMP, 32'h0000_ABCD);

      // PRESCALE=0, COMPARE=3, autoreload, IE
      wr(A_COUNT, 32'd0);
      wr(A_CMP, 32'd3);
      wr(A_CTRL, 32'h0000_0007);
      rd("t0_count_start", A_COUNT, 32'd0);
      seq = '{1, 2, 3, 0, 1};
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         rd($sformatf("t0_count_%0d", i), A_COUNT, 32'(seq[i-1]));
         chk($sformatf("t0_irq_%0d", i), {31'd0, irq}, (i >= 4) ? 32'd1 : 32'd0);
      end
      rd("t0_status_match", A_STATUS, 32'd1);
      wr(A_STATUS, 32'd1);
      chk("t0_irq_cleared", {31'd0, irq}, 32'd0);
      rd("t0_status_cleared", A_STATUS, 32'd0);
      rd("t0_count_after_w1c", A_COUNT, 32'd2);
      @(negedge clk);
      rd("t0_count_pre_rematch", A_COUNT, 32'd3);
      wr(A_STATUS, 32'd1);
      rd("w1c_vs_set_status", A_STATUS, 32'd1);
      chk("w1c_vs_set_irq", {31'd0, irq}, 32'd1);
      rd("w1c_vs_set_count", A_COUNT, 32'd0);
      wr(A_STATUS, 32'd1);
      rd("w1c_second", A_STATUS, 32'd0);
      wr(A_CTRL, 32'd0);
      rd("t0_stop_count", A_COUNT, 32'd2);
      repeat (3) @(negedge clk);
      rd("t0_hold_count", A_COUNT, 32'd2);

      // PRESCALE=4
      wr(A_COUNT, 32'd0);
      wr(A_CTRL, 32'h0000_0401);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         rd($sformatf("presc4_k%0d", k), A_COUNT, 32'(k / 5));
      end
      wr(A_CTRL, 32'h0000_0400);
      rd("presc4_disable", A_COUNT, 32'd2);
      repeat (10) @(negedge clk);
      rd("presc4_hold", A_COUNT, 32'd2);

      // overflow
      wr(A_STATUS, 32'd3);
      wr(A_COUNT, 32'hFFFF_FFFE);
      wr(A_CMP, 32'd0);
      wr(A_CTRL, 32'h0000_0001);
      rd("ovf_start", A_COUNT, 32'hFFFF_FFFE);
      @(negedge clk);
      rd("ovf_tick1", A_COUNT, 32'hFFFF_FFFF);
      @(negedge clk);
      rd("ovf_tick2_count", A_COUNT, 32'd0);
      rd("ovf_tick2_status", A_STATUS, 32'd2);
      @(negedge clk);
      rd("ovf_tick3_count", A_COUNT, 32'd1);
      rd("ovf_tick3_status", A_STATUS, 32'd3);
      chk("ovf_irq_ie_off", {31'd0, irq}, 32'd0);
      wr(A_CTRL, 32'd0);

      // COUNT write beats tick, no match evaluated
      wr(A_STATUS, 32'd3);
      wr(A_COUNT, 32'd5);
      wr(A_CMP, 32'd5);
      wr(A_CTRL, 32'h0000_0001);
      wr(A_COUNT, 32'h10);
      rd("cnt_wr_beats_tick", A_COUNT, 32'h10);
      rd("cnt_wr_no_match", A_STATUS, 32'd0);
      @(negedge clk);
      rd("cnt_wr_then_tick", A_COUNT, 32'h11);
      wr(A_CTRL, 32'd0);

      // GPIO synchronizer
      gpio_in = 32'hDEAD_BEEF;
      rd("gin_edge0", A_GIN, 32'd0);
      @(negedge clk);
      rd("gin_edge1", A_GIN, 32'd0);
      @(negedge clk);
      rd("gin_edge2", A_GIN, 32'hDEAD_BEEF);
      wr(A_GIN, 32'd0);
      rd("gin_write_ignored", A_GIN, 32'hDEAD_BEEF);

      // reset mid-operation
      wr(A_COUNT, 32'd0);
      wr(A_CTRL, 32'h0000_0001);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_gpio_out", gpio_out, 32'h0000_00A5);
      rd("midrst_count", A_COUNT, 32'd0);
      rd("midrst_gin", A_GIN, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rd("postrst_count_held", A_COUNT, 32'd0);
      rd("postrst_gin", A_GIN, 32'hDEAD_BEEF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
